// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcode constants, execute-stage state encoding and shared widths.
package cpu_pkg;
  localparam int REG_ADDR_W_DEF = 3;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} exec_state_e;
endpackage

// File: rtl/exec_sequencer.sv
// exec_sequencer: fixed 4-cycle execute controller; reads two operands through one RF port, drives the ALU, writes back.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter bit R0_WRITE_LOCK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_alu_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_use_imm,
  input  logic [15:0]           in_imm,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [15:0]           rf_rdata,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [2:0]            alu_op,
  input  logic [15:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [15:0]           rf_wdata,
  output logic                  z_flag,
  output logic                  done
);
  exec_state_e state, state_next;
  logic [2:0]            alu_op_q;
  logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q, raddr_q;
  logic                  use_imm_q, zq;
  logic [15:0]           imm_q, op_a_q, res_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = in_valid ? RD_A : IDLE;
      RD_A: state_next = RD_B;
      RD_B: state_next = EXEC;
      EXEC: state_next = WB;
      default: state_next = IDLE;
    endcase
  end

  // The read address is held between reads so the RF port sees no spurious changes.
  always_comb begin
    in_ready = state == IDLE;
    rf_raddr = state == RD_A ? rs1_q : state == RD_B ? rs2_q : raddr_q;
    alu_a    = op_a_q;
    alu_b    = use_imm_q ? imm_q : rf_rdata;
    alu_op   = alu_op_q;
    rf_we    = state == WB && !(R0_WRITE_LOCK && rd_q == '0);
    rf_waddr = rd_q;
    rf_wdata = res_q;
    done     = state == WB;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_op_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      raddr_q   <= '0;
      op_a_q    <= '0;
      res_q     <= '0;
      zq        <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      raddr_q <= rf_raddr;
      if (state == IDLE && in_valid) begin
        alu_op_q  <= in_alu_op;
        rd_q      <= in_rd;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        use_imm_q <= in_use_imm;
        imm_q     <= in_imm;
      end
      if (state == RD_B) op_a_q <= rf_rdata;
      if (state == EXEC) begin
        res_q <= alu_result;
        zq    <= alu_zero;
      end
      if (state == WB) z_flag <= zq;
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: randomized and directed checks of exec_sequencer against an instruction-level reference model.
module tb_exec_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        use_imm;
    logic [15:0] imm;
  } instr_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_use_imm = 1'b0;
  logic [2:0] in_alu_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [15:0] in_imm = '0;
  logic [2:0] rf_raddr, rf_waddr, alu_op;
  logic [15:0] rf_rdata = '0, alu_a, alu_b, alu_result, rf_wdata;
  logic alu_zero, rf_we, z_flag, done;

  logic [15:0] env_r [8];
  logic [15:0] ref_r [8];
  logic ref_z;
  int n_tests = 0, n_fail = 0;

  exec_sequencer #(.REG_ADDR_W(3), .R0_WRITE_LOCK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .z_flag(z_flag), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOT: return ~a;
      ALU_SHL: return a << b[3:0];
      default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
  endfunction

  // Environment: combinational ALU and a register file with one-cycle read latency.
  always_comb begin
    alu_result = alu_f(alu_op, alu_a, alu_b);
    alu_zero   = alu_result == 16'd0;
  end

  always @(posedge clk) begin
    rf_rdata <= env_r[rf_raddr];
    if (rf_we) env_r[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] op, rd, rs1, rs2, input logic ui, input logic [15:0] imm);
    instr_t i;
    i = '{op: op, rd: rd, rs1: rs1, rs2: rs2, use_imm: ui, imm: imm};
    return i;
  endfunction

  function automatic instr_t rnd();
    return mk(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom));
  endfunction

  task automatic drive(input instr_t i);
    in_valid   = 1'b1;
    in_alu_op  = i.op;
    in_rd      = i.rd;
    in_rs1     = i.rs1;
    in_rs2     = i.rs2;
    in_use_imm = i.use_imm;
    in_imm     = i.imm;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of cycle T+5.
  task automatic run(input instr_t i, input bit hold, input instr_t nx, input int abort_at);
    logic [15:0] a, b, r;
    logic we;
    a  = ref_r[i.rs1];
    b  = i.use_imm ? i.imm : ref_r[i.rs2];
    r  = alu_f(i.op, a, b);
    we = i.rd != 3'd0;
    drive(i);
    check("ready_T", in_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) drive(nx);
        else in_valid = 1'b0;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_z", z_flag, 0);
        check("abort_we", rf_we, 0);
        check("abort_done", done, 0);
        ref_z = 1'b0;
        @(negedge clk);
        check("abort_hold_we", rf_we, 0);
        rst_n = 1'b1;
        return;
      end
      if (k <= 4) check("ready_busy", in_ready, 0);
      case (k)
        1: begin
          check("raddr_rs1", rf_raddr, i.rs1);
          check("done_early", done, 0);
        end
        2: check("raddr_rs2", rf_raddr, i.rs2);
        3: begin
          check("alu_a", alu_a, a);
          check("alu_b", alu_b, b);
          check("alu_op", alu_op, i.op);
          check("we_early", rf_we, 0);
        end
        4: begin
          check("wb_we", rf_we, we);
          check("wb_waddr", rf_waddr, i.rd);
          check("wb_wdata", rf_wdata, r);
          check("wb_done", done, 1);
          if (we) ref_r[i.rd] = r;
          ref_z = r == 16'd0;
        end
        default: begin
          check("ready_T5", in_ready, 1);
          check("done_after", done, 0);
          check("we_after", rf_we, 0);
          check("z_flag", z_flag, ref_z);
          check("rf_contents", env_r[i.rd], ref_r[i.rd]);
        end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t cur, nx, none;
    none = '0;
    for (int j = 0; j < 8; j++) begin
      env_r[j] = (j == 0) ? 16'd0 : 16'($urandom);
      ref_r[j] = env_r[j];
    end
    env_r[1] = 16'h0005; ref_r[1] = 16'h0005;
    env_r[2] = 16'h0003; ref_r[2] = 16'h0003;
    ref_z = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_z", z_flag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_raddr", rf_raddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(mk(ALU_SUB, 3, 1, 2, 0, 0), 0, none, 0);
    check("sub_wdata", ref_r[3], 16'h0002);
    run(mk(ALU_XOR, 4, 1, 1, 0, 0), 0, none, 0);
    check("xor_z", z_flag, 1);
    run(mk(ALU_SHL, 5, 2, 0, 1, 16'h0004), 0, none, 0);
    check("shl_wdata", env_r[5], 16'h0030);
    run(mk(ALU_SLT, 0, 1, 2, 0, 0), 0, none, 0);
    check("slt_r0", env_r[0], 16'h0000);
    run(mk(ALU_SUB, 7, 1, 2, 0, 0), 0, none, 3);
    run(mk(ALU_ADD, 6, 1, 2, 0, 0), 0, none, 0);
    check("add_wdata", env_r[6], 16'h0008);
    run(mk(ALU_OR, 3, 1, 2, 0, 0), 1, mk(ALU_AND, 4, 1, 2, 0, 0), 0);
    run(mk(ALU_AND, 4, 1, 2, 0, 0), 0, none, 0);
    cur = rnd();
    for (int n = 0; n < 60; n++) begin
      nx = rnd();
      run(cur, 1'($urandom), nx, 0);
      cur = nx;
    end
    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle execute controller that sits directly upstream of the 16-bit ALU and downstream of instruction decode. It accepts one decoded register/immediate ALU instruction over a valid/ready handshake and reads both source operands through the register file's single read port. It drives the ALU operands and opcode, captures the ALU result and zero flag, then writes the result back and updates the architectural Z flag. Fixed latency: 4 cycles from acceptance to writeback.

## Interface
- REG_ADDR_W, 3, register index width (8 registers)
- R0_WRITE_LOCK, 1, when 1, writes to r0 are suppressed

- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  block can accept (high only in IDLE)
- in_alu_op  in  3  ALU opcode, passed through to the ALU
- in_rd / in_rs1 / in_rs2  in  REG_ADDR_W  destination / source A / source B
- in_use_imm  in  1  operand B = in_imm instead of rs2
- in_imm  in  16  immediate
- rf_raddr  out  REG_ADDR_W  register file read address
- rf_rdata  in  16  read data; valid the cycle after rf_raddr is presented
- alu_a, alu_b  out  16  ALU operands
- alu_op  out  3  ALU opcode
- alu_result  in  16  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- rf_we  out  1  write-enable strobe, one cycle
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  16  write data
- z_flag  out  1  architectural zero flag, registered
- done  out  1  one-cycle pulse when the instruction retires

## Operation
- States: IDLE, RD_A, RD_B, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid: latch alu_op, rd, rs1, rs2, use_imm and imm, then go to RD_A.
- RD_A: rf_raddr=rs1_q, then go to RD_B.
- RD_B: rf_raddr=rs2_q; op_a_q<=rf_rdata; go to EXEC.
- EXEC:
  - alu_a=op_a_q; alu_b = use_imm_q ? imm_q : rf_rdata; alu_op=alu_op_q.
  - res_q<=alu_result; zq<=alu_zero; go to WB.
- WB:
  - rf_we=1, unless R0_WRITE_LOCK and rd_q==0.
  - rf_waddr=rd_q; rf_wdata=res_q; z_flag<=zq; done=1; go to IDLE.
- Immediate instructions still pass through RD_B. rs2_q is read and discarded, so latency stays constant.
- Outside EXEC: alu_a=op_a_q, alu_b per the same mux, alu_op=alu_op_q. The values are don't-care but stable.
- rf_raddr holds its last value in IDLE, EXEC and WB.
- A write to r0 when locked: done still pulses and z_flag still updates (compare-only use).
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing
- Acceptance cycle T (in_valid & in_ready).
  - T+1: RD_A
  - T+2: RD_B
  - T+3: EXEC
  - T+4: WB, with rf_we and done high
  - T+5: in_ready high again
- Minimum issue interval: 5 cycles. in_ready is low from T+1 to T+4.
- Reset values (asynchronous; hold while rst_n=0):
  - state=IDLE, so in_ready=1
  - rf_we=0, done=0, z_flag=0
  - all latched fields and op/res registers = 0, so alu_a=alu_b=0, alu_op=0, rf_raddr=0
- Reset mid-operation: abort immediately. No rf_we, no done, z_flag=0. The next instruction is accepted normally.
- in_valid while busy is ignored. Upstream must hold it until in_ready is seen.
- rf_wdata and rf_waddr are stable for the whole WB cycle. The register file commits on the clk edge ending WB.

## Structure
- Shared package cpu_pkg:
  - ALU opcode constants: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHL=110, SLT=111
  - exec state enum
  - REG_ADDR_W default
- No sub-module. The ALU and register file are instantiated by the parent datapath and wired to this block's ports.

## Test plan
Bench preload for all cases: r1=0x0005, r2=0x0003.
- SUB rd=3, rs1=1, rs2=2 → rf_raddr 1 at T+1 and 2 at T+2; at T+4 rf_we=1, waddr=3, wdata=0x0002, z_flag=0 after T+4, done pulses once.
- XOR rd=4, rs1=1, rs2=1 → wdata=0x0000, z_flag=1.
- SHL rd=5, rs1=2, use_imm=1, imm=0x0004 → wdata=0x0030, latency still 4.
- SLT rd=0, rs1=1, rs2=2 → rf_we stays 0; done pulses; z_flag=1 (result 0).
- Reset asserted during EXEC → no rf_we, in_ready=1 and z_flag=0 immediately. A following ADD rd=6 of r1 and r2 writes 0x0008.
- in_valid held high with two back-to-back instructions → second accepted at T+5; in_ready low T+1 to T+4; two done pulses 5 cycles apart.
